// File: rtl/cache_fill_fsm.sv
// Cache-miss fill controller: stalls the requester, streams BLOCK_WORDS reads to
// main memory, writes each returned word into the data array and tags the block.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_detected,
  input  logic [15:0]                    miss_address,
  input  logic                           memory_data_valid,
  input  logic [15:0]                    memory_data,
  output logic                           fsm_busy,
  output logic                           mem_read_en,
  output logic [15:0]                    memory_address,
  output logic                           write_data_array,
  output logic                           write_tag_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_index,
  output logic [15:0]                    fill_data
);

  localparam int IDX_W   = $clog2(BLOCK_WORDS);
  localparam int ISSUE_W = IDX_W + 1;
  localparam logic [15:0] OFFSET_MASK = 16'(2 * BLOCK_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state_reg, state_next;
  logic [15:0]        base_reg, base_next;
  logic [ISSUE_W-1:0] issue_cnt_reg, issue_cnt_next;
  logic [IDX_W-1:0]   recv_cnt_reg, recv_cnt_next;
  logic               issuing;
  logic               last_word;

  assign issuing   = (state_reg == FILL) && (issue_cnt_reg < ISSUE_W'(BLOCK_WORDS));
  assign last_word = (recv_cnt_reg == IDX_W'(BLOCK_WORDS - 1));

  // State and datapath registers; reset takes effect without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      base_reg      <= 16'h0000;
      issue_cnt_reg <= '0;
      recv_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      base_reg      <= base_next;
      issue_cnt_reg <= issue_cnt_next;
      recv_cnt_reg  <= recv_cnt_next;
    end
  end

  // Next-state logic: requests and returns are counted independently, so
  // completion depends only on the number of returned words, not the latency.
  always_comb begin
    state_next     = state_reg;
    base_next      = base_reg;
    issue_cnt_next = issue_cnt_reg;
    recv_cnt_next  = recv_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (miss_detected) begin
          state_next     = FILL;
          base_next      = miss_address & ~OFFSET_MASK;
          issue_cnt_next = '0;
          recv_cnt_next  = '0;
        end
      end
      FILL: begin
        if (issuing)
          issue_cnt_next = issue_cnt_reg + 1'b1;
        if (memory_data_valid) begin
          recv_cnt_next = recv_cnt_reg + 1'b1;
          if (last_word)
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic; the stall is raised combinationally in the miss cycle itself.
  always_comb begin
    fsm_busy         = (state_reg == FILL) || miss_detected;
    mem_read_en      = issuing;
    memory_address   = 16'h0000;
    if (issuing)
      memory_address = base_reg + (16'(issue_cnt_reg) << 1);
    write_data_array = (state_reg == FILL) && memory_data_valid;
    write_tag_array  = (state_reg == FILL) && memory_data_valid && last_word;
    fill_word_index  = recv_cnt_reg;
    fill_data        = memory_data;
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: aligned fill, top-of-memory block, gapped
// returns, miss held through a fill, asynchronous reset mid-fill, idle returns.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [2:0]  fill_word_index;
  logic [15:0] fill_data;

  int n_checks = 0;
  int n_fails  = 0;

  cache_fill_fsm #(.BLOCK_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .fsm_busy(fsm_busy), .mem_read_en(mem_read_en), .memory_address(memory_address),
    .write_data_array(write_data_array), .write_tag_array(write_tag_array),
    .fill_word_index(fill_word_index), .fill_data(fill_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the falling edge; outputs are checked 1 time unit later.
  task automatic cyc(input logic miss, input logic [15:0] maddr, input logic v, input logic [15:0] d);
    @(negedge clk);
    miss_detected     = miss;
    miss_address      = maddr;
    memory_data_valid = v;
    memory_data       = d;
    #1;
  endtask

  initial begin
    int n;
    logic v;
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = 16'h0000;
    memory_data_valid = 1'b0;
    memory_data = 16'h0000;

    // Reset values
    @(negedge clk); #1;
    chk("rst_busy", fsm_busy, 0);
    chk("rst_rd", mem_read_en, 0);
    chk("rst_addr", memory_address, 16'h0000);
    chk("rst_wda", write_data_array, 0);
    chk("rst_tag", write_tag_array, 0);
    chk("rst_idx", fill_word_index, 0);
    @(negedge clk);
    rst = 1'b0;

    // Miss at 0x1236, memory latency 4: reads cycles 1..8, word k written at 5+k
    cyc(1'b1, 16'h1236, 1'b0, 16'h0000);
    chk("t1_busy0", fsm_busy, 1);
    chk("t1_rd0", mem_read_en, 0);
    for (int c = 1; c <= 13; c++) begin
      v = (c >= 5) && (c <= 12);
      cyc(1'b0, 16'h0000, v, 16'hD000 + 16'(c - 5));
      chk("t1_rd", mem_read_en, c <= 8);
      if (c <= 8) chk("t1_addr", memory_address, 16'h1230 + 16'(2 * (c - 1)));
      chk("t1_wda", write_data_array, v);
      if (v) begin
        chk("t1_idx", fill_word_index, c - 5);
        chk("t1_data", fill_data, 16'hD000 + 16'(c - 5));
      end
      chk("t1_tag", write_tag_array, c == 12);
      chk("t1_busy", fsm_busy, c <= 12);
    end

    // Miss at 0xFFFF with returns on even cycles only (gaps between words)
    cyc(1'b1, 16'hFFFF, 1'b0, 16'h0000);
    chk("t2_busy0", fsm_busy, 1);
    n = 0;
    for (int c = 1; c <= 17; c++) begin
      v = (c >= 2) && (c <= 16) && (c % 2 == 0);
      cyc(1'b0, 16'h0000, v, 16'hA000 + 16'(n));
      chk("t2_rd", mem_read_en, c <= 8);
      if (c <= 8) chk("t2_addr", memory_address, 16'hFFF0 + 16'(2 * (c - 1)));
      chk("t2_wda", write_data_array, v);
      if (v) chk("t2_idx", fill_word_index, n);
      chk("t2_tag", write_tag_array, v && (n == 7));
      chk("t2_busy", fsm_busy, c <= 16);
      if (v) n++;
    end

    // Miss held high with a changing address: base stays 0x4000, then a second fill at 0x5670
    cyc(1'b1, 16'h4000, 1'b0, 16'h0000);
    for (int c = 1; c <= 10; c++) begin
      v = (c >= 2) && (c <= 9);
      cyc(1'b1, 16'h5678, v, 16'hB000 + 16'(c - 2));
      chk("t3_rd", mem_read_en, c <= 8);
      if (c <= 8) chk("t3_addr", memory_address, 16'h4000 + 16'(2 * (c - 1)));
      chk("t3_wda", write_data_array, v);
      chk("t3_tag", write_tag_array, c == 9);
      chk("t3_busy", fsm_busy, 1);
    end
    cyc(1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("t3b_rd", mem_read_en, 1);
    chk("t3b_addr", memory_address, 16'h5670);
    for (int c = 12; c <= 14; c++) begin
      cyc(1'b0, 16'h0000, 1'b1, 16'hC000 + 16'(c - 12));
      chk("t3b_addr", memory_address, 16'h5670 + 16'(2 * (c - 11)));
      chk("t3b_wda", write_data_array, 1);
      chk("t3b_idx", fill_word_index, c - 12);
    end

    // Asynchronous reset after three words, between clock edges
    @(negedge clk);
    memory_data_valid = 1'b1;
    memory_data = 16'hC003;
    #2;
    rst = 1'b1;
    #1;
    chk("t4_busy", fsm_busy, 0);
    chk("t4_rd", mem_read_en, 0);
    chk("t4_addr", memory_address, 16'h0000);
    chk("t4_wda", write_data_array, 0);
    chk("t4_tag", write_tag_array, 0);
    chk("t4_idx", fill_word_index, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc(1'b0, 16'h0000, 1'b1, 16'hC004 + 16'(c));
      chk("t4_stale_wda", write_data_array, 0);
      chk("t4_stale_tag", write_tag_array, 0);
      chk("t4_stale_busy", fsm_busy, 0);
      chk("t4_stale_rd", mem_read_en, 0);
    end

    // Returns while idle with no miss: nothing written, data still passes through
    cyc(1'b0, 16'h0000, 1'b1, 16'h5A5A);
    chk("t5_wda", write_data_array, 0);
    chk("t5_busy", fsm_busy, 0);
    chk("t5_data", fill_data, 16'h5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
